// File: rtl/counter_bank_pkg.sv
// counter_bank_pkg: shared FSM state type, saturate-mode constants and channel-index width helper
package counter_bank_pkg;
  typedef enum logic {IDLE, HOLD} state_t;
  localparam int COUNT_WRAP = 0;
  localparam int COUNT_SAT  = 1;
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/counter_cell.sv
// counter_cell: one WIDTH-bit event counter with sync clear, increment, wrap/saturate and a registered overflow pulse
module counter_cell
  import counter_bank_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int SATURATE = COUNT_WRAP
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);
  logic at_max;
  assign at_max = &count;
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      wrap  <= !clr && inc && at_max;
      count <= clr ? '0 : !inc ? count : (at_max && SATURATE == COUNT_SAT) ? count : count + 1'b1;
    end
  end
endmodule

// File: rtl/counter_bank.sv
// counter_bank: CHANNELS event counters with wrap/saturate overflow pulses and a valid/ready snapshot readout
// Ports: clk_i/rstn_i clock and async active-low reset; enable_i gates inc_i; clear_i per-channel clear;
//        rd_valid_i/rd_chan_i/rd_ready_o request side; data_o/data_valid_o/data_ready_i response side;
//        wrap_o per-channel overflow pulse.
// Build option: COUNTER_BANK_CLEAR_ON_READ_EN makes an accepted read also clear the selected channel.
module counter_bank
  import counter_bank_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int CHANNELS = 4,
  parameter  int SATURATE = COUNT_WRAP,
  localparam int CH_W     = ch_width(CHANNELS)
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                enable_i,
  input  logic [CHANNELS-1:0] inc_i,
  input  logic [CHANNELS-1:0] clear_i,
  input  logic                rd_valid_i,
  input  logic [CH_W-1:0]     rd_chan_i,
  output logic                rd_ready_o,
  output logic [WIDTH-1:0]    data_o,
  output logic                data_valid_o,
  input  logic                data_ready_i,
  output logic [CHANNELS-1:0] wrap_o
);
  state_t state_q, state_d;
  logic accept;
  logic [WIDTH-1:0] cnt [CHANNELS];
  logic [WIDTH-1:0] sel;
  logic [CHANNELS-1:0] rd_clr;
  assign accept = state_q == IDLE && rd_valid_i;
  assign rd_ready_o = state_q == IDLE;
  assign data_valid_o = state_q == HOLD;
  // Out-of-range channels match no entry, so they read 0 and clear nothing.
  always_comb begin
    sel = '0;
    rd_clr = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (rd_chan_i == CH_W'(k)) sel = cnt[k];
`ifdef COUNTER_BANK_CLEAR_ON_READ_EN
      rd_clr[k] = accept && rd_chan_i == CH_W'(k);
`endif
    end
  end
  genvar g;
  generate
    for (g = 0; g < CHANNELS; g++) begin : g_cell
      counter_cell #(.WIDTH(WIDTH), .SATURATE(SATURATE)) u_cell (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .clr    (clear_i[g] | rd_clr[g]),
        .inc    (enable_i & inc_i[g]),
        .count  (cnt[g]),
        .wrap   (wrap_o[g])
      );
    end
  endgenerate
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && rd_valid_i) state_d = HOLD;
    if (state_q == HOLD && data_ready_i) state_d = IDLE;
  end
  // Snapshot takes the pre-update count, so a same-cycle increment or clear is not seen.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      data_o  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) data_o <= sel;
    end
  end
endmodule

// File: tb/tb_counter_bank.sv
// tb_counter_bank: scoreboard bench running wrap and saturate instances side by side against a cycle model
module tb_counter_bank;
  localparam int W  = 8;
  localparam int CH = 5;
  localparam int CW = 3;
  localparam int MX = 255;
  logic clk_i = 0, rstn_i = 0, enable_i = 0, rd_valid_i = 0, data_ready_i = 1;
  logic [CH-1:0] inc_i = '0, clear_i = '0, wrap_o, wrap_s;
  logic [CW-1:0] rd_chan_i = '0;
  logic rd_ready_o, rd_ready_s, data_valid_o, data_valid_s;
  logic [W-1:0] data_o, data_s;
  int n_chk = 0, n_pass = 0;
  int m0 [CH], m1 [CH];
  int q0 [$], q1 [$];
  int e0 = 0, e1 = 0;
  bit busy = 0, seen = 0;
  always #5 clk_i = ~clk_i;
  counter_bank #(.WIDTH(W), .CHANNELS(CH), .SATURATE(0)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .enable_i(enable_i), .inc_i(inc_i), .clear_i(clear_i),
    .rd_valid_i(rd_valid_i), .rd_chan_i(rd_chan_i), .rd_ready_o(rd_ready_o), .data_o(data_o),
    .data_valid_o(data_valid_o), .data_ready_i(data_ready_i), .wrap_o(wrap_o));
  counter_bank #(.WIDTH(W), .CHANNELS(CH), .SATURATE(1)) dut_s (
    .clk_i(clk_i), .rstn_i(rstn_i), .enable_i(enable_i), .inc_i(inc_i), .clear_i(clear_i),
    .rd_valid_i(rd_valid_i), .rd_chan_i(rd_chan_i), .rd_ready_o(rd_ready_s), .data_o(data_s),
    .data_valid_o(data_valid_s), .data_ready_i(data_ready_i), .wrap_o(wrap_s));
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
  endtask
  task automatic do_reset();
    rstn_i = 0;
    {enable_i, rd_valid_i} = '0;
    {inc_i, clear_i} = '0;
    data_ready_i = 1;
    #3;
    check("rst_wrap", wrap_o, 0);
    check("rst_wrap_sat", wrap_s, 0);
    check("rst_ready", {rd_ready_s, rd_ready_o}, 2'b11);
    check("rst_valid", {data_valid_s, data_valid_o}, 0);
    check("rst_data", {data_s, data_o}, 0);
    for (int k = 0; k < CH; k++) begin m0[k] = 0; m1[k] = 0; end
    q0.delete(); q1.delete();
    busy = 0; seen = 0;
    @(negedge clk_i) rstn_i = 1;
  endtask
  task automatic tick();
    bit acc;
    logic [CH-1:0] clr, w0, w1;
    acc = rd_valid_i && !busy;
    clr = clear_i;
    w0 = '0; w1 = '0;
    if (acc) begin
      q0.push_back(rd_chan_i < CH ? m0[rd_chan_i] : 0);
      q1.push_back(rd_chan_i < CH ? m1[rd_chan_i] : 0);
`ifdef COUNTER_BANK_CLEAR_ON_READ_EN
      if (rd_chan_i < CH) clr[rd_chan_i] = 1'b1;
`endif
    end
    busy = busy ? !data_ready_i : acc;
    for (int k = 0; k < CH; k++) begin
      if (clr[k]) begin
        m0[k] = 0; m1[k] = 0;
      end else if (enable_i && inc_i[k]) begin
        if (m0[k] == MX) begin m0[k] = 0; w0[k] = 1; end else m0[k]++;
        if (m1[k] == MX) w1[k] = 1; else m1[k]++;
      end
    end
    @(posedge clk_i); #1;
    check("wrap", wrap_o, w0);
    check("wrap_sat", wrap_s, w1);
    check("rd_ready", {rd_ready_s, rd_ready_o}, {2{!busy}});
    check("data_valid", {data_valid_s, data_valid_o}, {2{busy}});
    if (data_valid_o && !seen) begin
      if (q0.size() == 0 || q1.size() == 0) check("queue_empty", 0, 1);
      else begin e0 = q0.pop_front(); e1 = q1.pop_front(); end
    end
    seen = data_valid_o;
    if (data_valid_o) begin
      check("data", data_o, e0);
      check("data_sat", data_s, e1);
    end
  endtask
  task automatic read(input int c);
    rd_valid_i = 1; rd_chan_i = CW'(c);
    tick();
    rd_valid_i = 0;
    tick();
    tick();
  endtask
  initial begin
    do_reset();
    enable_i = 1;
    inc_i = 5'b00001; repeat (5) tick();
    inc_i = '0; read(0);
    inc_i = 5'b00010; repeat (256) tick();
    inc_i = '0; repeat (2) tick();
    read(1);
    inc_i = 5'b00100; repeat (258) tick();
    inc_i = '0; tick(); read(2);
    inc_i = 5'b01000; repeat (255) tick();
    clear_i = 5'b01000; tick();
    clear_i = '0; inc_i = '0; tick(); read(3);
    data_ready_i = 0; inc_i = 5'b00001; rd_valid_i = 1; rd_chan_i = 0;
    repeat (5) tick();
    rd_valid_i = 0; data_ready_i = 1;
    tick(); tick();
    inc_i = '0;
    read(7); read(6); read(4);
    clear_i = 5'b00001; tick();
    clear_i = '0; inc_i = 5'b00001; repeat (7) tick();
    rd_valid_i = 1; rd_chan_i = 0; tick();
    rd_valid_i = 0; inc_i = '0; tick(); tick();
    read(0);
    enable_i = 0; inc_i = 5'b11111; tick(); inc_i = '0; read(0);
    enable_i = 1; inc_i = 5'b00010; repeat (3) tick(); inc_i = '0;
    rd_valid_i = 1; rd_chan_i = 1; tick();
    rd_valid_i = 0; data_ready_i = 0; tick();
    do_reset();
    enable_i = 1; tick(); read(1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/counter_bank.md
Name: counter_bank

Overview:
- Multi-channel, parametrised event counter bank with a per-channel increment and clear, plus a valid/ready snapshot readout port.
- Generalises the single free-running counter pattern to CHANNELS independent counters of WIDTH bits.
- Each bank has selectable wrap or saturate mode and registered overflow pulses.
- Sits beside datapath blocks to count qualified events for status/debug readout.

Parameters:
- WIDTH, 8, counter and readout data width in bits (>= 2).
- CHANNELS, 4, number of independent counters (>= 1).
- SATURATE, 0, overflow mode: 0 wraps to 0 past the maximum; 1 holds at 2**WIDTH-1.
- CH_W (localparam), max(1, $clog2(CHANNELS)), width of the channel index.

Ports:
- clk_i  input  1  clock; all logic on the rising edge.
- rstn_i  input  1  asynchronous active-low reset.
- enable_i  input  1  global count enable; gates all inc_i.
- inc_i  input  CHANNELS  per-channel increment request.
- clear_i  input  CHANNELS  per-channel synchronous clear; not gated by enable_i.
- rd_valid_i  input  1  readout request valid.
- rd_chan_i  input  CH_W  channel to read; sampled with rd_valid_i.
- rd_ready_o  output  1  readout request accepted when high.
- data_o  output  WIDTH  captured counter value.
- data_valid_o  output  1  data_o valid.
- data_ready_i  input  1  consumer accepts data_o.
- wrap_o  output  CHANNELS  one-cycle overflow pulse per channel.

Behaviour:
- Reset, asynchronous on rstn_i low: all counters 0, wrap_o 0, data_o 0, data_valid_o 0, FSM in IDLE, rd_ready_o 1.
- Counter k update, per cycle, in priority order:
  - clear_i[k]: count <= 0.
  - else enable_i & inc_i[k]: count <= count+1.
  - else hold.
- Counter arithmetic is unsigned modulo 2**WIDTH.
- Overflow when count = 2**WIDTH-1 and an increment is accepted:
  - SATURATE=0: count <= 0.
  - SATURATE=1: count stays at 2**WIDTH-1.
  - Either mode: wrap_o[k] = 1 on the next cycle only. In saturate mode it pulses again on every further accepted increment at max.
  - A clear in the same cycle suppresses the overflow and the wrap_o pulse.
- Readout FSM states: IDLE and HOLD.
  - IDLE: rd_ready_o = 1, data_valid_o = 0. On rd_valid_i=1, capture the count of rd_chan_i as it stood before this cycle's update into data_o, then go to HOLD.
  - HOLD: rd_ready_o = 0, data_valid_o = 1, data_o stable. On data_ready_i=1, go to IDLE. rd_ready_o is 1 the following cycle; no back-to-back acceptance.
- Latency: data_valid_o rises 1 cycle after the request handshake; wrap_o rises 1 cycle after the overflowing increment.
- Out-of-range rd_chan_i (>= CHANNELS): data_o captures 0; the handshake completes normally.
- rd_valid_i in HOLD is ignored; the requester must hold it until rd_ready_o is high.
- Counting continues in every FSM state; the snapshot is never updated while in HOLD.
- Reset mid-readout: FSM returns to IDLE and the snapshot is lost.

Optional Feature:
- Macro: COUNTER_BANK_CLEAR_ON_READ_EN.
- Defined: the request handshake also clears the selected channel in the same cycle. A concurrent increment to that channel gives count = 1. The captured value is the pre-clear count. An out-of-range channel clears nothing.
- Undefined: reads are non-destructive.

Decomposition:
- Package counter_bank_pkg holds:
  - the FSM state typedef (IDLE, HOLD);
  - a channel-index width function, max(1, clog2(n));
  - the SATURATE mode constants COUNT_WRAP = 0 and COUNT_SAT = 1.
- Sub-module counter_cell: one WIDTH counter with clear/inc/wrap-pulse logic and the SATURATE parameter, instantiated CHANNELS times in a generate loop.
- FSM and readout mux stay in counter_bank.

Test Plan:
- Reset then 5 cycles with enable_i=1, inc_i=4'b0001 -> count0=5, others 0. Read channel 0 -> data_o=5, data_valid_o high 1 cycle after the handshake.
- WIDTH=8, SATURATE=0: preload count1 to 255 via increments, then 1 more increment -> count1=0, wrap_o[1]=1 for exactly one cycle.
- WIDTH=8, SATURATE=1: count2 at 255, 3 more increments -> count stays 255, 3 wrap_o[2] pulses.
- clear_i[3]=1 and inc_i[3]=1 with enable_i=1 in the same cycle, count3=255 -> count3=0, no wrap_o[3].
- Request channel 0 with data_ready_i=0 for 4 cycles while still incrementing -> data_o stays at the snapshot, rd_ready_o=0 throughout, IDLE one cycle after data_ready_i=1. rd_chan_i=5 with CHANNELS=4 -> data_o=0.
- With COUNTER_BANK_CLEAR_ON_READ_EN defined: count0=7, read plus concurrent inc_i[0] -> data_o=7, count0=1. Undefined: count0=8.
